// File: rtl/y86_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : y86_seq_controller
// Description : Multi-cycle stage sequencer for the Y86-64 SEQ processor;
//               owns the PC, status and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
  input  logic [63:0]      new_pc,
  output logic [63:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pcupdate_en,
  output logic             mem_req,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXECUTE   = 4'd3,
    MEMORY    = 4'd4,
    WRITEBACK = 4'd5,
    PCUPDATE  = 4'd6,
    HALTED    = 4'd7,
    ERROR     = 4'd8
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] icode_q;
  logic [2:0] stat_nxt;
  logic       mem_icode;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  always_comb begin
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_icode = 1'b1;
      default:                            mem_icode = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    stat_nxt     = stat;
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    execute_en   = 1'b0;
    memory_en    = 1'b0;
    writeback_en = 1'b0;
    pcupdate_en  = 1'b0;
    mem_req      = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_en = 1'b1;
        busy     = 1'b1;
        if (imem_error) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_ADR;
        end else if (!instr_valid) begin
          state_nxt = ERROR;
          stat_nxt  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_nxt = HALTED;
          stat_nxt  = STAT_HLT;
        end else begin
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        decode_en = 1'b1;
        busy      = 1'b1;
        state_nxt = EXECUTE;
      end
      EXECUTE: begin
        execute_en = 1'b1;
        busy       = 1'b1;
        state_nxt  = MEMORY;
      end
      MEMORY: begin
        memory_en = 1'b1;
        busy      = 1'b1;
        if (mem_icode) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            if (dmem_error) begin
              state_nxt = ERROR;
              stat_nxt  = STAT_ADR;
            end else begin
              state_nxt = WRITEBACK;
            end
          end
        end else begin
          state_nxt = WRITEBACK;
        end
      end
      WRITEBACK: begin
        writeback_en = 1'b1;
        busy         = 1'b1;
        state_nxt    = PCUPDATE;
      end
      PCUPDATE: begin
        pcupdate_en = 1'b1;
        busy        = 1'b1;
        state_nxt   = run ? FETCH : IDLE;
      end
      HALTED, ERROR: begin
        state_nxt = state;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      icode_q <= 4'h0;
      pc      <= RESET_PC;
      stat    <= STAT_AOK;
      retired <= '0;
    end else begin
      state <= state_nxt;
      stat  <= stat_nxt;
      if (state == FETCH && state_nxt == DECODE) icode_q <= icode;
      if (state == PCUPDATE) begin
        pc      <= new_pc;
        retired <= retired + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_seq_controller
// Description : Randomized self-checking bench with an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_seq_controller;

  localparam logic [63:0] RESET_PC = 64'h100;
  localparam int unsigned CNT_W    = 32;

  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_F    = 6'b100000;
  localparam logic [5:0] EN_D    = 6'b010000;
  localparam logic [5:0] EN_E    = 6'b001000;
  localparam logic [5:0] EN_M    = 6'b000100;
  localparam logic [5:0] EN_W    = 6'b000010;
  localparam logic [5:0] EN_P    = 6'b000001;

  logic clk = 1'b0;
  logic rst_n, run, instr_valid, imem_error, mem_ack, dmem_error;
  logic [3:0] icode;
  logic [63:0] new_pc, pc;
  logic fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupdate_en;
  logic mem_req, busy;
  logic [2:0] stat;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;

  // instruction-level model of architectural state
  logic [63:0] exp_pc;
  logic [2:0]  exp_stat;
  longint      exp_retired;
  bit          exp_idle;

  always #5 clk = ~clk;

  y86_seq_controller #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .mem_ack(mem_ack), .dmem_error(dmem_error), .new_pc(new_pc),
    .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .execute_en(execute_en), .memory_en(memory_en),
    .writeback_en(writeback_en), .pcupdate_en(pcupdate_en),
    .mem_req(mem_req), .stat(stat), .busy(busy), .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input string where, input logic [5:0] en, input logic req);
    check_eq({where, " enables"},
             {58'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en, pcupdate_en},
             {58'd0, en});
    check_eq({where, " mem_req"}, {63'd0, mem_req}, {63'd0, req});
    check_eq({where, " busy"}, {63'd0, busy}, {63'd0, (en != EN_NONE)});
    check_eq({where, " pc"}, pc, exp_pc);
    check_eq({where, " stat"}, {61'd0, stat}, {61'd0, exp_stat});
    check_eq({where, " retired"}, {32'd0, retired}, exp_retired[31:0]);
  endtask

  task automatic scramble();
    icode       = 4'($urandom);
    instr_valid = 1'($urandom);
    imem_error  = 1'($urandom);
    mem_ack     = 1'($urandom);
    dmem_error  = 1'($urandom);
    new_pc      = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    exp_pc      = RESET_PC;
    exp_stat    = 3'd1;
    exp_retired = 0;
    exp_idle    = 1'b1;
  endtask

  // reset asserted asynchronously away from the clock edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    model_reset();
    check_cycle({tag, " async"}, EN_NONE, 1'b0);
    @(negedge clk);
    check_cycle({tag, " held"}, EN_NONE, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic terminal_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_cycle("terminal", EN_NONE, 1'b0);
      scramble();
      run = 1'($urandom);
    end
  endtask

  // Walks one instruction; expected stage sequence follows from the icode,
  // fault flags and ack delay. abort_at>=0 pulses reset in that MEMORY cycle.
  task automatic do_instr(input logic [3:0] ic, input logic vld, input logic ierr,
                          input int ack_dly, input logic derr, input logic [63:0] npc,
                          input logic run_after, input int abort_at);
    bit memop;
    int n;
    memop = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
            (ic == 4'hA) || (ic == 4'hB);
    if (exp_idle) begin
      @(negedge clk);
      check_cycle("idle", EN_NONE, 1'b0);
      scramble();
      run      = 1'b1;
      exp_idle = 1'b0;
    end
    @(negedge clk);
    check_cycle("fetch", EN_F, 1'b0);
    scramble();
    icode       = ic;
    instr_valid = vld;
    imem_error  = ierr;
    run         = 1'($urandom);
    if (ierr || !vld || ic == 4'h0) begin
      exp_stat = ierr ? 3'd3 : (!vld ? 3'd4 : 3'd2);
      terminal_cycles(1);
      return;
    end
    @(negedge clk);
    check_cycle("decode", EN_D, 1'b0);
    scramble();
    @(negedge clk);
    check_cycle("execute", EN_E, 1'b0);
    scramble();
    run = 1'($urandom);
    n = 0;
    forever begin
      @(negedge clk);
      check_cycle("memory", EN_M, memop);
      scramble();
      if (!memop) break;
      if (abort_at >= 0 && n == abort_at) begin
        do_reset("abort");
        return;
      end
      mem_ack = (n == ack_dly);
      if (mem_ack) dmem_error = derr;
      n++;
      if (mem_ack) break;
      if (n > 50) begin
        check_eq("ack bound", 64'(n), 64'(ack_dly));
        return;
      end
    end
    if (memop && derr) begin
      exp_stat = 3'd3;
      terminal_cycles(1);
      return;
    end
    @(negedge clk);
    check_cycle("writeback", EN_W, 1'b0);
    scramble();
    @(negedge clk);
    check_cycle("pcupdate", EN_P, 1'b0);
    scramble();
    new_pc = npc;
    run    = run_after;
    exp_pc      = npc;
    exp_retired = exp_retired + 1;
    exp_idle    = !run_after;
  endtask

  initial begin
    logic [3:0] ic;
    rst_n = 1'b0;
    run   = 1'b0;
    scramble();
    model_reset();
    repeat (2) @(negedge clk);
    check_cycle("reset", EN_NONE, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle("idle no run", EN_NONE, 1'b0);

    // OPq, then mrmovq with late ack, back-to-back
    do_instr(4'h6, 1'b1, 1'b0, 0, 1'b0, 64'h102, 1'b1, -1);
    do_instr(4'h5, 1'b1, 1'b0, 3, 1'b0, 64'h10c, 1'b0, -1);
    // run dropped mid-instruction, resume from updated pc
    do_instr(4'h2, 1'b1, 1'b0, 0, 1'b0, 64'h200, 1'b0, -1);
    do_instr(4'h8, 1'b1, 1'b0, 1, 1'b0, 64'h300, 1'b1, -1);
    // halt
    do_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 64'h0, 1'b1, -1);
    terminal_cycles(5);
    do_reset("after halt");
    // ADR priority over INS, then INS alone
    do_instr(4'h6, 1'b0, 1'b1, 0, 1'b0, 64'h0, 1'b1, -1);
    terminal_cycles(2);
    do_reset("after adr");
    do_instr(4'h6, 1'b0, 1'b0, 0, 1'b0, 64'h0, 1'b1, -1);
    terminal_cycles(2);
    do_reset("after ins");
    // pushq with data fault
    do_instr(4'h3, 1'b1, 1'b0, 0, 1'b0, 64'h40a, 1'b1, -1);
    do_instr(4'hA, 1'b1, 1'b0, 2, 1'b1, 64'h999, 1'b1, -1);
    terminal_cycles(3);
    do_reset("after dmem");
    // reset pulse during MEMORY
    do_instr(4'h1, 1'b1, 1'b0, 0, 1'b0, 64'h500, 1'b1, -1);
    do_instr(4'h9, 1'b1, 1'b0, 5, 1'b0, 64'h600, 1'b1, 2);

    for (int t = 0; t < 400; t++) begin
      ic = ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_instr(ic, ($urandom_range(0, 15) != 0), ($urandom_range(0, 31) == 0),
               int'($urandom_range(0, 4)), ($urandom_range(0, 15) == 0),
               {$urandom, $urandom}, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0) ? 1 : -1);
      if (exp_stat != 3'd1) begin
        terminal_cycles(2);
        do_reset("random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/y86_seq_controller.md
# y86_seq_controller

Multi-cycle sequencer for the Y86-64 SEQ processor. It owns the architectural PC register and walks each instruction through fetch, decode, execute, memory, writeback and PC-update, asserting one stage enable per cycle. It holds the memory stage on a request/acknowledge handshake with data memory, loads `new_pc` from the PC-update datapath, and tracks processor status (AOK/HLT/ADR/INS). It sits between the top-level run control and the stage datapath blocks.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = keep issuing instructions, 0 = stop at the next instruction boundary.
- `icode`  in  4  icode from the fetch datapath; valid during FETCH.
- `instr_valid`  in  1  fetch decoder flag: icode/ifun are legal; valid during FETCH.
- `imem_error`  in  1  instruction-fetch address error; valid during FETCH.
- `mem_ack`  in  1  data-memory acknowledge; sampled only in MEMORY while `mem_req`=1.
- `dmem_error`  in  1  data-memory address error; sampled with `mem_ack`.
- `new_pc`  in  64  next-PC from the PC-update datapath; sampled in PCUPDATE.
- `pc`  out  64  architectural PC, registered.
- `fetch_en`, `decode_en`, `execute_en`, `memory_en`, `writeback_en`, `pcupdate_en`  out  1 each  one-hot stage enables, decoded from state.
- `mem_req`  out  1  data-memory request.
- `stat`  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS, registered.
- `busy`  out  1  high in any stage state.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED, ERROR.
- IDLE: all enables are 0. Go to FETCH when `run`=1.
- FETCH: `fetch_en`=1. Checks at the end of the cycle, in priority order:
  - `imem_error` -> ERROR with stat=ADR.
  - else `instr_valid`=0 -> ERROR with stat=INS.
  - else `icode`=4'h0 (halt) -> HALTED with stat=HLT.
  - else -> DECODE.
  - `icode` is latched internally on the FETCH -> DECODE transition.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY: `memory_en`=1.
  - Memory-accessing latched icodes are 4, 5, 8, 9, A, B. For these, `mem_req`=1 until a cycle with `mem_ack`=1.
    - On ack with `dmem_error`=1 -> ERROR with stat=ADR.
    - On ack with `dmem_error`=0 -> WRITEBACK.
    - With no ack, stay in MEMORY indefinitely.
  - For any other icode, `mem_req`=0 and the state lasts one cycle.
- WRITEBACK: one cycle -> PCUPDATE.
- PCUPDATE: `pcupdate_en`=1.
  - `pc` <= `new_pc` and `retired` increments (wraps modulo 2^CNT_W).
  - Next state is FETCH if `run`=1, else IDLE.
- HALTED and ERROR are terminal until `rst_n` is asserted.
  - `pc` is not updated and stays at the faulting or halt instruction.
  - All enables and `mem_req` are 0; `stat` is held.
- `run` is sampled only in IDLE and PCUPDATE. Dropping it mid-instruction completes that instruction.
- `mem_ack` outside MEMORY, or with `mem_req`=0, is ignored.

## Timing
- Reset values (asynchronous): state=IDLE, `pc`=RESET_PC, `stat`=1 (AOK), `retired`=0, `mem_req`=0, all enables 0, `busy`=0.
- Reset asserted mid-instruction aborts immediately. No PC or counter update occurs.
- Instruction latency, FETCH to the last PCUPDATE cycle:
  - 6 cycles for non-memory icodes.
  - 5 + N cycles for memory icodes, where N≥1 is the number of MEMORY cycles up to and including the ack cycle. Ack in the first MEMORY cycle gives 6.
- Continuous `run`=1 issues back-to-back instructions: FETCH follows PCUPDATE with no bubble.
- First FETCH occurs the cycle after IDLE samples `run`=1.
- Updated `pc` is visible in the FETCH cycle following PCUPDATE.
- `stat` changes in the same edge as entry to HALTED or ERROR.
- Enables and `mem_req` are combinational from registered state and latched icode. They are glitch-free relative to `clk`.

## Test plan
- Reset with RESET_PC=0x100, then `run`=1, icode=6 (OPq), valid, `new_pc`=0x102 -> FETCH..PCUPDATE in 6 cycles, one enable per cycle. Then `pc`=0x102, `retired`=1, next cycle FETCH.
- icode=5 (mrmovq), `mem_ack` delayed 3 cycles -> `mem_req` high 4 MEMORY cycles, total latency 9. `pc` takes `new_pc` and stat stays AOK.
- icode=0 at FETCH -> HALTED, stat=2, `pc` unchanged. Further `run` toggles and ack pulses cause no change. `rst_n` low returns to IDLE, pc=RESET_PC, stat=1.
- FETCH with `imem_error`=1 and `instr_valid`=0 together -> ERROR, stat=3 (ADR priority). Separately, `instr_valid`=0 alone -> stat=4.
- icode=A (pushq), ack with `dmem_error`=1 -> ERROR, stat=3, no WRITEBACK or PCUPDATE, `retired` unchanged.
- `run` dropped during EXECUTE -> instruction completes through PCUPDATE, then IDLE. Re-raising `run` resumes at the updated `pc`. `rst_n` pulse during MEMORY -> immediate IDLE, `mem_req`=0, `retired` unchanged.
